tug_light_bar: RTL and testbench
================================

// Module: tug_light_bar
// PURPOSE
//  Parametrised tug-of-war playfield replacing the per-LED normal/center light cells.
//  Owns the lit position, move logic, win detection and per-player scores for NUM_LIGHTS LEDs.
//  Sits between the key-conditioning stage (single-cycle L/R pulses) and the LEDR/HEX drivers.
// PARAMETERS
//  NUM_LIGHTS   9   LEDs in the bar; odd, >=3; index NUM_LIGHTS-1 is leftmost
//  MAX_SCORE    7   rounds needed to win the match; >=1
//  ROUND_GAP    50  cycles held in a win state before auto-recenter (AUTO_ROUND_EN only); >=1
//  localparam CENTER = NUM_LIGHTS/2; SW = $clog2(MAX_SCORE+1)
// PORTS
//  clk        in   1           system clock
//  reset      in   1           asynchronous, active-high; full match reset
//  L          in   1           left-player press pulse, one cycle per press
//  R          in   1           right-player press pulse, one cycle per press
//  resetround in   1           synchronous recenter request; scores kept
//  lights     out  NUM_LIGHTS  one-hot lit position; all-zero outside PLAY
//  win_l      out  1           one-cycle pulse: left player took a round
//  win_r      out  1           one-cycle pulse: right player took a round
//  score_l    out  SW          left rounds won, saturates at MAX_SCORE
//  score_r    out  SW          right rounds won, saturates at MAX_SCORE
//  match_over out  1           high once either score equals MAX_SCORE
// BEHAVIOUR
//  - Reset: state=PLAY, pos=CENTER, lights=1<<CENTER, scores=0, win_l=win_r=0, match_over=0.
//  - All outputs registered; a press at edge k shows on lights after edge k.
//  - States: PLAY, WIN_L, WIN_R, DONE.
//  - PLAY, move=L^R (both or neither = no move, hold):
//      L only & pos<NUM_LIGHTS-1 -> pos+1;  R only & pos>0 -> pos-1.
//      L only & pos==NUM_LIGHTS-1 -> WIN_L, win_l pulse, score_l+1.
//      R only & pos==0            -> WIN_R, win_r pulse, score_r+1.
//  - Win increment reaching MAX_SCORE -> DONE, not WIN_x; match_over set same edge as score.
//  - WIN_L/WIN_R: lights=0, L/R ignored; resetround -> PLAY, pos=CENTER.
//  - DONE: lights=0; L, R, resetround ignored; only reset exits.
//  - resetround in PLAY: pos=CENTER, state PLAY; overrides L/R same cycle.
//  - win_l/win_r high exactly one cycle per round; never both.
//  - Scores never wrap; match_over stays high until reset.
//  - reset asserted any cycle (incl. mid-press, WIN, DONE) -> reset values immediately.
// CONFIGURATION
//  AUTO_ROUND_EN defined: WIN_L/WIN_R count cycles; after ROUND_GAP cycles in the
//    state, auto-recenter to PLAY, pos=CENTER; counter clears on exit; resetround
//    still recenters early.
//  AUTO_ROUND_EN undefined: no counter; WIN states held until resetround or reset.
// TESTING
//  1 reset, 4 L pulses (NUM_LIGHTS=9) -> lights 0x020,0x040,0x080,0x100; 5th L -> lights=0, win_l 1 cycle, score_l=1
//  2 PLAY at pos 4, L&R same cycle x3 -> lights stay 0x010, no win pulses
//  3 pos 0, R pulse -> WIN_R, score_r=1; L/R in WIN ignored; resetround -> lights=0x010
//  4 MAX_SCORE=2: two left wins -> score_l=2, match_over=1, DONE; resetround/L/R -> no change; reset -> 0x010, scores 0
//  5 resetround and L same cycle at pos 6 -> lights=0x010; reset mid-WIN_L -> PLAY, scores 0 immediately
//  6 AUTO_ROUND_EN, ROUND_GAP=5: win_l -> lights=0 for 5 cycles, then 0x010; undefined -> holds until resetround

Source files
------------

// File: rtl/tug_light_bar.sv
// tug_light_bar: tug-of-war playfield for a bar of NUM_LIGHTS LEDs.
// Holds the lit position, moves it on single-cycle L/R press pulses, detects round wins,
// keeps per-player scores and flags the end of the match.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high full match reset
//   L, R        left/right player press pulses (one cycle per press)
//   resetround  synchronous recenter request; scores are kept
//   lights      one-hot lit position (index NUM_LIGHTS-1 is leftmost); zero outside play
//   win_l/win_r one-cycle pulse when the left/right player takes a round
//   score_l/r   rounds won per player, saturating at MAX_SCORE
//   match_over  set once either score reaches MAX_SCORE, held until reset
//
// Optional feature: define AUTO_ROUND_EN to leave a win state automatically after
// ROUND_GAP cycles. Without it a win state is held until resetround or reset.
module tug_light_bar #(
  parameter int unsigned NUM_LIGHTS = 9,
  parameter int unsigned MAX_SCORE  = 7,
  parameter int unsigned ROUND_GAP  = 50,
  localparam int unsigned SW        = $clog2(MAX_SCORE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  resetround,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  win_l,
  output logic                  win_r,
  output logic [SW-1:0]         score_l,
  output logic [SW-1:0]         score_r,
  output logic                  match_over
);

  localparam int unsigned PW = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0] Center = PW'(NUM_LIGHTS / 2);
  localparam logic [PW-1:0] Last   = PW'(NUM_LIGHTS - 1);
  localparam logic [SW-1:0] ScoreM1 = SW'(MAX_SCORE - 1);

  typedef enum logic [1:0] {StPlay, StWinL, StWinR, StDone} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [SW-1:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic                  win_l_q, win_l_d, win_r_q, win_r_d;
  logic                  match_q, match_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;

`ifdef AUTO_ROUND_EN
  localparam int unsigned CW = $clog2(ROUND_GAP + 1);
  localparam logic [CW-1:0] GapM1 = CW'(ROUND_GAP - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_round_gap;
  assign unused_round_gap = ^ROUND_GAP;
`endif

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    win_l_d   = 1'b0;
    win_r_d   = 1'b0;
    match_d   = match_q;
`ifdef AUTO_ROUND_EN
    cnt_d     = '0;
`endif
    case (state_q)
      StPlay: begin
        if (resetround) begin
          pos_d = Center;
        end else if (L && !R) begin
          if (pos_q == Last) begin
            score_l_d = score_l_q + 1'b1;
            win_l_d   = 1'b1;
            // The deciding round goes straight to DONE instead of a win state.
            if (score_l_q == ScoreM1) begin
              state_d = StDone;
              match_d = 1'b1;
            end else begin
              state_d = StWinL;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (R && !L) begin
          if (pos_q == '0) begin
            score_r_d = score_r_q + 1'b1;
            win_r_d   = 1'b1;
            if (score_r_q == ScoreM1) begin
              state_d = StDone;
              match_d = 1'b1;
            end else begin
              state_d = StWinR;
            end
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      StWinL, StWinR: begin
        if (resetround) begin
          state_d = StPlay;
          pos_d   = Center;
`ifdef AUTO_ROUND_EN
        end else if (cnt_q == GapM1) begin
          state_d = StPlay;
          pos_d   = Center;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: ;  // StDone: only reset leaves
    endcase

    lights_d = '0;
    if (state_d == StPlay) lights_d[pos_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StPlay;
      pos_q     <= Center;
      score_l_q <= '0;
      score_r_q <= '0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      match_q   <= 1'b0;
      lights_q  <= NUM_LIGHTS'(1) << (NUM_LIGHTS / 2);
`ifdef AUTO_ROUND_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
      match_q   <= match_d;
      lights_q  <= lights_d;
`ifdef AUTO_ROUND_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign lights     = lights_q;
  assign win_l      = win_l_q;
  assign win_r      = win_r_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign match_over = match_q;

endmodule

// File: tb/tb_tug_light_bar.sv
module tb_tug_light_bar;

  logic       clk = 1'b0;
  logic       reset;
  logic       l1, r1, rr1;
  logic [8:0] lights1;
  logic       wl1, wr1, mo1;
  logic [2:0] sl1, sr1;

  logic       l2, r2, rr2;
  logic [8:0] lights2;
  logic       wl2, wr2, mo2;
  logic [1:0] sl2, sr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tug_light_bar #(.NUM_LIGHTS(9), .MAX_SCORE(7), .ROUND_GAP(5)) dut (
    .clk(clk), .reset(reset), .L(l1), .R(r1), .resetround(rr1),
    .lights(lights1), .win_l(wl1), .win_r(wr1), .score_l(sl1), .score_r(sr1),
    .match_over(mo1)
  );

  tug_light_bar #(.NUM_LIGHTS(9), .MAX_SCORE(2), .ROUND_GAP(50)) dut2 (
    .clk(clk), .reset(reset), .L(l2), .R(r2), .resetround(rr2),
    .lights(lights2), .win_l(wl2), .win_r(wr2), .score_l(sl2), .score_r(sr2),
    .match_over(mo2)
  );

  task automatic step(input logic l, input logic r, input logic rr);
    @(negedge clk);
    l1 = l; r1 = r; rr1 = rr;
    @(posedge clk);
    #1;
    l1 = 1'b0; r1 = 1'b0; rr1 = 1'b0;
  endtask

  task automatic step2(input logic l, input logic r, input logic rr);
    @(negedge clk);
    l2 = l; r2 = r; rr2 = rr;
    @(posedge clk);
    #1;
    l2 = 1'b0; r2 = 1'b0; rr2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (lights1 !== 9'h010 || sl1 !== 3'd0 || sr1 !== 3'd0 || wl1 !== 1'b0 || wr1 !== 1'b0 ||
        mo1 !== 1'b0) begin
      errors++;
      $display("FAIL reset: lights=%h sl=%0d sr=%0d wl=%b wr=%b mo=%b exp 010/0/0/0/0/0",
               lights1, sl1, sr1, wl1, wr1, mo1);
    end
  endtask

  task automatic test_left_walk();
    logic [8:0] exp [4];
    exp[0] = 9'h020; exp[1] = 9'h040; exp[2] = 9'h080; exp[3] = 9'h100;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (lights1 !== exp[i] || wl1 !== 1'b0) begin
        errors++;
        $display("FAIL walk%0d: lights=%h wl=%b exp %h/0", i, lights1, wl1, exp[i]);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (lights1 !== 9'h000 || wl1 !== 1'b1 || wr1 !== 1'b0 || sl1 !== 3'd1 || mo1 !== 1'b0) begin
      errors++;
      $display("FAIL win_l: lights=%h wl=%b wr=%b sl=%0d mo=%b exp 000/1/0/1/0",
               lights1, wl1, wr1, sl1, mo1);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (lights1 !== 9'h000 || wl1 !== 1'b0 || sl1 !== 3'd1) begin
      errors++;
      $display("FAIL win_l_pulse: lights=%h wl=%b sl=%0d exp 000/0/1", lights1, wl1, sl1);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (lights1 !== 9'h010 || sl1 !== 3'd1) begin
      errors++;
      $display("FAIL recenter: lights=%h sl=%0d exp 010/1", lights1, sl1);
    end
  endtask

  task automatic test_both_press();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (lights1 !== 9'h010 || wl1 !== 1'b0 || wr1 !== 1'b0) begin
        errors++;
        $display("FAIL both%0d: lights=%h wl=%b wr=%b exp 010/0/0", i, lights1, wl1, wr1);
      end
    end
  endtask

  task automatic test_right_win();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (lights1 !== 9'h001) begin
      errors++;
      $display("FAIL right_edge: lights=%h exp 001", lights1);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (lights1 !== 9'h000 || wr1 !== 1'b1 || wl1 !== 1'b0 || sr1 !== 3'd1 || sl1 !== 3'd1) begin
      errors++;
      $display("FAIL win_r: lights=%h wr=%b wl=%b sr=%0d sl=%0d exp 000/1/0/1/1",
               lights1, wr1, wl1, sr1, sl1);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (lights1 !== 9'h000 || wr1 !== 1'b0 || wl1 !== 1'b0 || sr1 !== 3'd1 || sl1 !== 3'd1) begin
      errors++;
      $display("FAIL win_r_ignore: lights=%h wr=%b wl=%b sr=%0d sl=%0d exp 000/0/0/1/1",
               lights1, wr1, wl1, sr1, sl1);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (lights1 !== 9'h010) begin
      errors++;
      $display("FAIL win_r_recenter: lights=%h exp 010", lights1);
    end
  endtask

  task automatic test_resetround_priority();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (lights1 !== 9'h040) begin
      errors++;
      $display("FAIL pos6: lights=%h exp 040", lights1);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (lights1 !== 9'h010) begin
      errors++;
      $display("FAIL rr_over_l: lights=%h exp 010", lights1);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (lights1 !== 9'h000 || sl1 !== 3'd2) begin
      errors++;
      $display("FAIL second_win_l: lights=%h sl=%0d exp 000/2", lights1, sl1);
    end
    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (lights1 !== 9'h010 || sl1 !== 3'd0 || sr1 !== 3'd0 || mo1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: lights=%h sl=%0d sr=%0d mo=%b exp 010/0/0/0",
               lights1, sl1, sr1, mo1);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_match_done();
    do_reset();
    for (int i = 0; i < 5; i++) step2(1'b1, 1'b0, 1'b0);
    checks++;
    if (sl2 !== 2'd1 || mo2 !== 1'b0 || wl2 !== 1'b1) begin
      errors++;
      $display("FAIL done_first: sl=%0d mo=%b wl=%b exp 1/0/1", sl2, mo2, wl2);
    end
    step2(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step2(1'b1, 1'b0, 1'b0);
    checks++;
    if (sl2 !== 2'd2 || mo2 !== 1'b1 || wl2 !== 1'b1 || lights2 !== 9'h000) begin
      errors++;
      $display("FAIL done_enter: sl=%0d mo=%b wl=%b lights=%h exp 2/1/1/000",
               sl2, mo2, wl2, lights2);
    end
    step2(1'b0, 1'b0, 1'b1);
    step2(1'b1, 1'b0, 1'b0);
    step2(1'b0, 1'b1, 1'b0);
    checks++;
    if (sl2 !== 2'd2 || sr2 !== 2'd0 || mo2 !== 1'b1 || wl2 !== 1'b0 || wr2 !== 1'b0 ||
        lights2 !== 9'h000) begin
      errors++;
      $display("FAIL done_hold: sl=%0d sr=%0d mo=%b wl=%b wr=%b lights=%h exp 2/0/1/0/0/000",
               sl2, sr2, mo2, wl2, wr2, lights2);
    end
    do_reset();
    #1;
    checks++;
    if (lights2 !== 9'h010 || sl2 !== 2'd0 || mo2 !== 1'b0) begin
      errors++;
      $display("FAIL done_reset: lights=%h sl=%0d mo=%b exp 010/0/0", lights2, sl2, mo2);
    end
  endtask

  task automatic test_round_gap();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
`ifdef AUTO_ROUND_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (lights1 !== 9'h000) begin
        errors++;
        $display("FAIL gap_hold%0d: lights=%h exp 000", i, lights1);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (lights1 !== 9'h010 || sl1 !== 3'd1) begin
      errors++;
      $display("FAIL gap_expire: lights=%h sl=%0d exp 010/1", lights1, sl1);
    end
`else
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (lights1 !== 9'h000) begin
        errors++;
        $display("FAIL gap_hold%0d: lights=%h exp 000", i, lights1);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (lights1 !== 9'h010 || sl1 !== 3'd1) begin
      errors++;
      $display("FAIL gap_rr: lights=%h sl=%0d exp 010/1", lights1, sl1);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    l1 = 1'b0; r1 = 1'b0; rr1 = 1'b0;
    l2 = 1'b0; r2 = 1'b0; rr2 = 1'b0;
    test_reset();
    test_left_walk();
    test_both_press();
    test_right_win();
    test_resetround_priority();
    test_match_done();
    test_round_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
